// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the polyphonic wave synthesiser:
//   - waveform select encodings (triangle, saw, square, noise)
//   - ADSR envelope state enum
//   - per-voice config register addresses
//   - noise LFSR seed, tap mask and step function
// -----------------------------------------------------------------------------
package wave_pkg;

   typedef enum logic [1:0] {
      WAVE_TRI   = 2'd0,
      WAVE_SAW   = 2'd1,
      WAVE_SQR   = 2'd2,
      WAVE_NOISE = 2'd3
   } wave_sel_e;

   typedef enum logic [2:0] {
      ADSR_IDLE    = 3'd0,
      ADSR_ATTACK  = 3'd1,
      ADSR_DECAY   = 3'd2,
      ADSR_SUSTAIN = 3'd3,
      ADSR_RELEASE = 3'd4
   } adsr_state_e;

   localparam logic [2:0] CFG_INC     = 3'd0;
   localparam logic [2:0] CFG_WAVE    = 3'd1;
   localparam logic [2:0] CFG_ATTACK  = 3'd2;
   localparam logic [2:0] CFG_DECAY   = 3'd3;
   localparam logic [2:0] CFG_SUSTAIN = 3'd4;
   localparam logic [2:0] CFG_RELEASE = 3'd5;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/wave_voice.sv
// -----------------------------------------------------------------------------
// wave_voice
// One synthesiser voice: config registers, NCO phase accumulator, noise LFSR,
// waveform shaper, ADSR envelope and the amplitude product.
// Ports:
//   clk, reset     clock / async active-high reset
//   tick           sample strobe (stage-1 update on this cycle's edge)
//   s1_valid       stage-1 results valid (stage-2 product update)
//   cfg_we         write strobe already decoded for this voice
//   cfg_addr       register address, cfg_data LSB-aligned write data
//   gate           note gate for this voice
//   active         high while the envelope is not IDLE
//   sample         registered wave * env >> WIDTH
// -----------------------------------------------------------------------------
module wave_voice
   import wave_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned INDEX   = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               s1_valid,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_addr,
   input  logic [PHASE_W-1:0] cfg_data,
   input  logic               gate,
   output logic               active,
   output logic [WIDTH-1:0]   sample
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [PHASE_W-1:0] inc_q, inc_d, phase_q, phase_d;
   wave_sel_e          wave_q, wave_d;
   logic [WIDTH-1:0]   att_q, att_d, dec_q, dec_d, sus_q, sus_d, rel_q, rel_d;
   logic [15:0]        lfsr_q, lfsr_d;
   adsr_state_e        state_q, state_d, eff;
   logic [WIDTH-1:0]   env_q, env_d, wav_q, wav_d, sample_q, sample_d;
   logic               gate_q, gate_d, carry;
   logic [WIDTH-1:0]   p, p_shl;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] rate_step(input logic [WIDTH-1:0] r);
      return (r == '0) ? MAX : r;
   endfunction

   always_comb begin
      inc_d  = inc_q;
      wave_d = wave_q;
      att_d  = att_q;
      dec_d  = dec_q;
      sus_d  = sus_q;
      rel_d  = rel_q;
      if (cfg_we) begin
         case (cfg_addr)
            CFG_INC:     inc_d  = cfg_data;
            CFG_WAVE:    wave_d = wave_sel_e'(cfg_data[1:0]);
            CFG_ATTACK:  att_d  = cfg_data[WIDTH-1:0];
            CFG_DECAY:   dec_d  = cfg_data[WIDTH-1:0];
            CFG_SUSTAIN: sus_d  = cfg_data[WIDTH-1:0];
            CFG_RELEASE: rel_d  = cfg_data[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      phase_d = phase_q;
      lfsr_d  = lfsr_q;
      gate_d  = gate_q;
      wav_d   = wav_q;
      state_d = state_q;
      env_d   = env_q;
      carry   = 1'b0;
      eff     = state_q;
      sum     = '0;
      p       = phase_q[PHASE_W-1 -: WIDTH];
      p_shl   = {p[WIDTH-2:0], 1'b0};
      if (tick) begin
         {carry, phase_d} = {1'b0, phase_q} + {1'b0, inc_q};
         if (carry) lfsr_d = lfsr_next(lfsr_q);
         gate_d = gate;
         // Wave is taken from the pre-increment phase so the first tick of a
         // note starts at phase 0.
         case (wave_q)
            WAVE_TRI: wav_d = p[WIDTH-1] ? ~p_shl : p_shl;
            WAVE_SAW: wav_d = p;
            WAVE_SQR: wav_d = p[WIDTH-1] ? '0 : MAX;
            default:  wav_d = lfsr_q[WIDTH-1:0];
         endcase
         // Gate edges redirect the state first; the step below then runs in
         // the redirected state, so edges take effect on the same tick.
         if (gate && !gate_q && (state_q == ADSR_IDLE || state_q == ADSR_RELEASE))
            eff = ADSR_ATTACK;
         else if (!gate && gate_q &&
                  (state_q == ADSR_ATTACK || state_q == ADSR_DECAY || state_q == ADSR_SUSTAIN))
            eff = ADSR_RELEASE;
         state_d = eff;
         case (eff)
            ADSR_IDLE: env_d = '0;
            ADSR_ATTACK: begin
               sum = {1'b0, env_q} + {1'b0, rate_step(att_q)};
               if (sum >= {1'b0, MAX}) begin
                  env_d   = MAX;
                  state_d = ADSR_DECAY;
               end else begin
                  env_d = sum[WIDTH-1:0];
               end
            end
            ADSR_DECAY: begin
               sum = {1'b0, sus_q} + {1'b0, rate_step(dec_q)};
               if ({1'b0, env_q} <= sum) begin
                  env_d   = sus_q;
                  state_d = ADSR_SUSTAIN;
               end else begin
                  env_d = env_q - rate_step(dec_q);
               end
            end
            ADSR_SUSTAIN: env_d = sus_q;
            ADSR_RELEASE: begin
               if (env_q <= rate_step(rel_q)) begin
                  env_d   = '0;
                  state_d = ADSR_IDLE;
               end else begin
                  env_d = env_q - rate_step(rel_q);
               end
            end
            default: begin
               env_d   = '0;
               state_d = ADSR_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      prod     = {{WIDTH{1'b0}}, wav_q} * {{WIDTH{1'b0}}, env_q};
      sample_d = s1_valid ? WIDTH'(prod >> WIDTH) : sample_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_q    <= '0;
         wave_q   <= WAVE_TRI;
         att_q    <= '0;
         dec_q    <= '0;
         sus_q    <= '0;
         rel_q    <= '0;
         phase_q  <= '0;
         lfsr_q   <= LFSR_SEED ^ 16'(INDEX);
         gate_q   <= 1'b0;
         wav_q    <= '0;
         state_q  <= ADSR_IDLE;
         env_q    <= '0;
         sample_q <= '0;
      end else begin
         inc_q    <= inc_d;
         wave_q   <= wave_d;
         att_q    <= att_d;
         dec_q    <= dec_d;
         sus_q    <= sus_d;
         rel_q    <= rel_d;
         phase_q  <= phase_d;
         lfsr_q   <= lfsr_d;
         gate_q   <= gate_d;
         wav_q    <= wav_d;
         state_q  <= state_d;
         env_q    <= env_d;
         sample_q <= sample_d;
      end
   end

   assign active = (state_q != ADSR_IDLE);
   assign sample = sample_q;

endmodule

// File: rtl/poly_wave_synth.sv
// -----------------------------------------------------------------------------
// poly_wave_synth
// VOICES-voice NCO/ADSR synthesiser mixed down to one sample stream.
// Ports:
//   clk, reset     clock / async active-high reset
//   sample_tick    one-cycle sample-rate strobe
//   cfg_we, cfg_voice, cfg_addr, cfg_data   per-voice config write port
//   gate           per-voice note gates
//   voice_active   per-voice envelope-not-idle flags
//   mix_out        averaged voice samples, held between updates
//   mix_valid      pulses 3 clks after each sample_tick
// -----------------------------------------------------------------------------
module poly_wave_synth
   import wave_pkg::*;
#(
   parameter int unsigned VOICES  = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PHASE_W = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_tick,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_voice,
   input  logic [2:0]         cfg_addr,
   input  logic [PHASE_W-1:0] cfg_data,
   input  logic [VOICES-1:0]  gate,
   output logic [VOICES-1:0]  voice_active,
   output logic [WIDTH-1:0]   mix_out,
   output logic               mix_valid
);

   localparam int unsigned LOG_V = (VOICES > 1) ? $clog2(VOICES) : 0;
   localparam int unsigned SUM_W = WIDTH + LOG_V;

   logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic               mix_valid_q, mix_valid_d;
   logic [WIDTH-1:0]   mix_q, mix_d;
   logic [VOICES-1:0]  voice_we;
   logic [WIDTH-1:0]   voice_sample [VOICES];
   logic [SUM_W-1:0]   sum;

   // Voice indices >= VOICES never match, so those writes are dropped.
   always_comb begin
      voice_we = '0;
      for (int unsigned i = 0; i < VOICES; i++)
         voice_we[i] = cfg_we && (cfg_voice == 3'(i));
   end

   for (genvar g = 0; g < VOICES; g++) begin : gen_voice
      wave_voice #(
         .WIDTH   (WIDTH),
         .PHASE_W (PHASE_W),
         .INDEX   (g)
      ) u_voice (
         .clk      (clk),
         .reset    (reset),
         .tick     (sample_tick),
         .s1_valid (s1_valid_q),
         .cfg_we   (voice_we[g]),
         .cfg_addr (cfg_addr),
         .cfg_data (cfg_data),
         .gate     (gate[g]),
         .active   (voice_active[g]),
         .sample   (voice_sample[g])
      );
   end

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < VOICES; i++)
         sum = sum + SUM_W'(voice_sample[i]);
      mix_d       = s2_valid_q ? WIDTH'(sum >> LOG_V) : mix_q;
      s1_valid_d  = sample_tick;
      s2_valid_d  = s1_valid_q;
      mix_valid_d = s2_valid_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         mix_valid_q <= 1'b0;
         mix_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         mix_valid_q <= mix_valid_d;
         mix_q       <= mix_d;
      end
   end

   assign mix_out   = mix_q;
   assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_poly_wave_synth.sv
// -----------------------------------------------------------------------------
// tb_poly_wave_synth
// Scoreboarded bench for poly_wave_synth (VOICES=4, WIDTH=8, PHASE_W=24).
// A behavioural voice model predicts each mixed sample at tick time; the
// monitor pops and compares on every mix_valid, including its latency.
// -----------------------------------------------------------------------------
module tb_poly_wave_synth;

   localparam int VOICES  = 4;
   localparam int WIDTH   = 8;
   localparam int PHASE_W = 24;

   localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_tick;
   logic               cfg_we;
   logic [2:0]         cfg_voice;
   logic [2:0]         cfg_addr;
   logic [PHASE_W-1:0] cfg_data;
   logic [VOICES-1:0]  gate;
   logic [VOICES-1:0]  voice_active;
   logic [WIDTH-1:0]   mix_out;
   logic               mix_valid;

   always #5 clk = ~clk;

   poly_wave_synth #(
      .VOICES  (VOICES),
      .WIDTH   (WIDTH),
      .PHASE_W (PHASE_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .cfg_we       (cfg_we),
      .cfg_voice    (cfg_voice),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .gate         (gate),
      .voice_active (voice_active),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int exp_mix;
      int due;
   } sb_t;
   sb_t sbq[$];
   sb_t mon_e;

   typedef struct {
      int g;
      int env;
      int act;
   } adsr_vec_t;
   adsr_vec_t tbl[22];

   int m_inc[VOICES], m_wave[VOICES], m_att[VOICES], m_dec[VOICES];
   int m_sus[VOICES], m_rel[VOICES], m_phase[VOICES], m_lfsr[VOICES];
   int m_st[VOICES], m_env[VOICES], m_gq[VOICES];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int stp(int r);
      return (r == 0) ? 255 : r;
   endfunction

   function automatic int lfsr_adv(int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | fb) & 32'hFFFF;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_inc[v] = 0; m_wave[v] = 0; m_att[v] = 0; m_dec[v] = 0;
         m_sus[v] = 0; m_rel[v] = 0; m_phase[v] = 0;
         m_lfsr[v] = 32'hACE1 ^ v;
         m_st[v] = S_IDLE; m_env[v] = 0; m_gq[v] = 0;
      end
      sbq.delete();
   endtask

   task automatic model_tick();
      int total;
      total = 0;
      for (int v = 0; v < VOICES; v++) begin
         int p, w, st, e, g, rise, fall;
         p = (m_phase[v] >> 16) & 255;
         st = m_st[v];
         e = m_env[v];
         g = int'(gate[v]);
         rise = (g == 1 && m_gq[v] == 0) ? 1 : 0;
         fall = (g == 0 && m_gq[v] == 1) ? 1 : 0;
         case (m_wave[v])
            0:       w = (p >= 128) ? (~(p << 1)) & 255 : (p << 1) & 255;
            1:       w = p;
            2:       w = (p >= 128) ? 0 : 255;
            default: w = m_lfsr[v] & 255;
         endcase
         if (rise == 1 && (st == S_IDLE || st == S_REL)) st = S_ATT;
         else if (fall == 1 && (st == S_ATT || st == S_DEC || st == S_SUS)) st = S_REL;
         case (st)
            S_ATT: begin
               e = e + stp(m_att[v]);
               if (e >= 255) begin e = 255; st = S_DEC; end
            end
            S_DEC: begin
               e = e - stp(m_dec[v]);
               if (e <= m_sus[v]) begin e = m_sus[v]; st = S_SUS; end
            end
            S_SUS: e = m_sus[v];
            S_REL: begin
               e = e - stp(m_rel[v]);
               if (e <= 0) begin e = 0; st = S_IDLE; end
            end
            default: e = 0;
         endcase
         m_st[v] = st;
         m_env[v] = e;
         m_gq[v] = g;
         total += (w * e) >> 8;
         m_phase[v] += m_inc[v];
         if (m_phase[v] >= (1 << 24)) begin
            m_phase[v] -= (1 << 24);
            m_lfsr[v] = lfsr_adv(m_lfsr[v]);
         end
      end
      sbq.push_back(sb_t'{total >> 2, cyc + 3});
   endtask

   task automatic do_ticks(int n, int gap);
      for (int k = 0; k < n; k++) begin
         sample_tick = 1'b1;
         model_tick();
         @(posedge clk); #1;
         sample_tick = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic cfg_write(int v, int a, int d);
      cfg_we = 1'b1;
      cfg_voice = 3'(v);
      cfg_addr = 3'(a);
      cfg_data = PHASE_W'(d);
      if (v < VOICES) begin
         case (a)
            0: m_inc[v] = d & 32'hFFFFFF;
            1: m_wave[v] = d & 3;
            2: m_att[v] = d & 255;
            3: m_dec[v] = d & 255;
            4: m_sus[v] = d & 255;
            5: m_rel[v] = d & 255;
            default: ;
         endcase
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic setup_voice(int v, int inc, int wave, int att, int dec, int sus, int rel);
      cfg_write(v, 0, inc);
      cfg_write(v, 1, wave);
      cfg_write(v, 2, att);
      cfg_write(v, 3, dec);
      cfg_write(v, 4, sus);
      cfg_write(v, 5, rel);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sbq.size() > 0; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d samples outstanding, expected 0", sbq.size());
      end
   endtask

   always @(negedge clk) begin
      if (!reset && mix_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious mix_valid: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("mix_out", int'(mix_out), mon_e.exp_mix);
            check("mix_valid latency", cyc, mon_e.due);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{
         '{1, 51, 1}, '{1, 102, 1}, '{1, 153, 1}, '{1, 204, 1}, '{1, 255, 1},
         '{1, 238, 1}, '{1, 221, 1}, '{1, 204, 1}, '{1, 187, 1}, '{1, 170, 1},
         '{1, 153, 1}, '{1, 153, 1},
         '{0, 102, 1},
         '{1, 153, 1}, '{1, 204, 1}, '{1, 255, 1},
         '{0, 204, 1}, '{0, 153, 1}, '{0, 102, 1}, '{0, 51, 1}, '{0, 0, 0}, '{0, 0, 0}
      };

      reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
      cfg_voice = '0; cfg_addr = '0; cfg_data = '0; gate = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset mix_out", int'(mix_out), 0);
      check("reset mix_valid", int'(mix_valid), 0);
      check("reset voice_active", int'(voice_active), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Saw on voice 0, instant envelope, back-to-back ticks.
      setup_voice(0, 32'h010000, 1, 0, 0, 255, 0);
      gate = 4'b0001;
      do_ticks(65, 0);
      drain();
      check("saw n=64 held", int'(mix_out), 15);
      gate = 4'b0000;
      do_ticks(1, 2);
      drain();
      check("saw released active", int'(voice_active), 0);

      // Square on voice 1, with ignored writes mid-stream.
      setup_voice(1, 32'h800000, 2, 0, 0, 255, 0);
      gate = 4'b0010;
      do_ticks(3, 1);
      cfg_write(5, 0, 32'h123456);
      cfg_write(5, 1, 3);
      cfg_write(1, 6, 32'h000001);
      cfg_write(1, 7, 32'h000001);
      cfg_write(0, 6, 32'h400000);
      do_ticks(3, 1);
      drain();
      check("square sixth tick", int'(mix_out), 0);

      // All four voices sounding, then reset while sustaining.
      setup_voice(2, 32'h030000, 0, 0, 0, 200, 0);
      setup_voice(3, 32'h400000, 3, 0, 0, 255, 0);
      gate = 4'b1111;
      do_ticks(12, 0);
      drain();
      check("all voices active", int'(voice_active), 15);
      reset = 1'b1;
      #1;
      check("async reset mix_out", int'(mix_out), 0);
      check("async reset mix_valid", int'(mix_valid), 0);
      check("async reset voice_active", int'(voice_active), 0);
      model_reset();
      gate = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_ticks(3, 1);
      drain();
      check("post-reset silent active", int'(voice_active), 0);

      // ADSR envelope table on voice 0: square at phase 0 gives full-scale wave.
      setup_voice(0, 0, 2, 51, 17, 153, 51);
      for (int i = 0; i < 22; i++) begin
         gate[0] = (tbl[i].g != 0);
         do_ticks(1, 0);
         @(posedge clk); #1;
         @(posedge clk); #1;
         check($sformatf("adsr[%0d] mix_out", i), int'(mix_out), ((255 * tbl[i].env) >> 8) >> 2);
         check($sformatf("adsr[%0d] active", i), int'(voice_active[0]), tbl[i].act);
         @(posedge clk); #1;
      end
      drain();

      // Noise voice: LFSR holds seed for 4 ticks, then shows one advance.
      setup_voice(3, 32'h400000, 3, 0, 0, 255, 0);
      gate = 4'b1000;
      do_ticks(4, 0);
      drain();
      check("noise seed sample", int'(mix_out), 56);
      do_ticks(1, 0);
      drain();
      check("noise first advance", int'(mix_out), 49);
      do_ticks(6, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
